// File: rtl/risc_controller.sv
// Instruction register and multi-cycle control FSM for the RISC datapath.
// Holds one instruction and sequences register-file reads, ALU and writeback.
module risc_controller (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        s,
   input  logic        load,
   input  logic [15:0] in,
   output logic        w,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  vsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5
);

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_DECODE,
      ST_GET_A,
      ST_GET_B,
      ST_ALU,
      ST_WR_REG,
      ST_WR_IMM
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] ir_reg, ir_next;

   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] rn;
   logic [2:0] rd;
   logic [2:0] rm;
   logic       is_movi, is_movr, is_add, is_cmp, is_and, is_mvn;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= ST_WAIT;
         ir_reg    <= '0;
      end else begin
         state_reg <= state_next;
         ir_reg    <= ir_next;
      end
   end

   // The IR only accepts a new word while idle, so fields stay stable per instruction.
   always_comb begin
      ir_next = ir_reg;
      if (state_reg == ST_WAIT && load)
         ir_next = in;
   end

   assign opcode = ir_reg[15:13];
   assign op     = ir_reg[12:11];
   assign rn     = ir_reg[10:8];
   assign rd     = ir_reg[7:5];
   assign rm     = ir_reg[2:0];

   assign is_movi = (opcode == 3'b110) && (op == 2'b10);
   assign is_movr = (opcode == 3'b110) && (op == 2'b00);
   assign is_add  = (opcode == 3'b101) && (op == 2'b00);
   assign is_cmp  = (opcode == 3'b101) && (op == 2'b01);
   assign is_and  = (opcode == 3'b101) && (op == 2'b10);
   assign is_mvn  = (opcode == 3'b101) && (op == 2'b11);

   assign shift = ir_reg[4:3];
   assign ALUop = is_movr ? 2'b00 : op;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_sext
         if (gi < 8) begin : g_lo8
            assign sximm8[gi] = ir_reg[gi];
         end else begin : g_hi8
            assign sximm8[gi] = ir_reg[7];
         end
         if (gi < 5) begin : g_lo5
            assign sximm5[gi] = ir_reg[gi];
         end else begin : g_hi5
            assign sximm5[gi] = ir_reg[4];
         end
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      w          = 1'b0;
      readnum    = 3'd0;
      writenum   = 3'd0;
      write      = 1'b0;
      loada      = 1'b0;
      loadb      = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      asel       = 1'b0;
      bsel       = 1'b0;
      vsel       = 2'b00;

      case (state_reg)
         ST_WAIT: begin
            w = 1'b1;
            if (s)
               state_next = ST_DECODE;
         end
         ST_DECODE: begin
            if (is_movi)
               state_next = ST_WR_IMM;
            else if (is_add || is_cmp || is_and)
               state_next = ST_GET_A;
            else if (is_movr || is_mvn)
               state_next = ST_GET_B;
            else
               state_next = ST_WAIT;
         end
         ST_GET_A: begin
            readnum    = rn;
            loada      = 1'b1;
            state_next = ST_GET_B;
         end
         ST_GET_B: begin
            readnum    = rm;
            loadb      = 1'b1;
            state_next = ST_ALU;
         end
         ST_ALU: begin
            // MOVR passes the shifted Rm through an ADD with a zeroed A operand.
            asel = is_movr;
            if (is_cmp) begin
               loads      = 1'b1;
               state_next = ST_WAIT;
            end else begin
               loadc      = 1'b1;
               state_next = ST_WR_REG;
            end
         end
         ST_WR_REG: begin
            writenum   = rd;
            vsel       = 2'b00;
            write      = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WR_IMM: begin
            writenum   = rn;
            vsel       = 2'b10;
            write      = 1'b1;
            state_next = ST_WAIT;
         end
         default: begin
            state_next = ST_WAIT;
         end
      endcase

      // Reset masks every strobe immediately, even mid-instruction.
      if (!reset_n) begin
         state_next = ST_WAIT;
         w          = 1'b1;
         readnum    = 3'd0;
         writenum   = 3'd0;
         write      = 1'b0;
         loada      = 1'b0;
         loadb      = 1'b0;
         loadc      = 1'b0;
         loads      = 1'b0;
         asel       = 1'b0;
         bsel       = 1'b0;
         vsel       = 2'b00;
      end
   end

endmodule

// File: tb/tb_risc_controller.sv
// Scoreboard bench for risc_controller: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_risc_controller;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        s;
   logic        load;
   logic [15:0] in;
   logic        w;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic        write;
   logic        loada, loadb, loadc, loads;
   logic        asel, bsel;
   logic [1:0]  vsel;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic [15:0] sximm8;
   logic [15:0] sximm5;

   always #5 clk = ~clk;

   risc_controller dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .s        (s),
      .load     (load),
      .in       (in),
      .w        (w),
      .readnum  (readnum),
      .writenum (writenum),
      .write    (write),
      .loada    (loada),
      .loadb    (loadb),
      .loadc    (loadc),
      .loads    (loads),
      .asel     (asel),
      .bsel     (bsel),
      .vsel     (vsel),
      .shift    (shift),
      .ALUop    (ALUop),
      .sximm8   (sximm8),
      .sximm5   (sximm5)
   );

   // strobe order: write loada loadb loadc loads asel bsel
   localparam logic [6:0] S_NONE = 7'b0000000;
   localparam logic [6:0] S_WR   = 7'b1000000;
   localparam logic [6:0] S_LA   = 7'b0100000;
   localparam logic [6:0] S_LB   = 7'b0010000;
   localparam logic [6:0] S_LC   = 7'b0001000;
   localparam logic [6:0] S_LS   = 7'b0000100;
   localparam logic [6:0] S_AS   = 7'b0000010;

   typedef struct {
      string       tag;
      logic [51:0] vec;
   } row_t;

   row_t        exp_q[$];
   row_t        mon_r;
   logic [51:0] mon_act;
   int          total = 0;
   int          bad   = 0;

   // IR-derived expectations for the instruction currently held
   logic [1:0]  f_shift = 2'b00;
   logic [1:0]  f_aluop = 2'b00;
   logic [15:0] f_sx8   = 16'h0000;
   logic [15:0] f_sx5   = 16'h0000;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_r   = exp_q.pop_front();
         mon_act = {w, readnum, writenum,
                    write, loada, loadb, loadc, loads, asel, bsel,
                    vsel, shift, ALUop, sximm8, sximm5};
         total++;
         if (mon_act !== mon_r.vec) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", mon_r.tag, mon_act, mon_r.vec);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ex(input string tag, input logic w_e, input logic [2:0] rn_e,
                     input logic [2:0] wn_e, input logic [6:0] str_e, input logic [1:0] vs_e);
      row_t r;
      r.tag = tag;
      r.vec = {w_e, rn_e, wn_e, str_e, vs_e, f_shift, f_aluop, f_sx8, f_sx5};
      exp_q.push_back(r);
   endtask

   task automatic setf(input logic [1:0] sh, input logic [1:0] al,
                       input logic [15:0] x8, input logic [15:0] x5);
      f_shift = sh;
      f_aluop = al;
      f_sx8   = x8;
      f_sx5   = x5;
   endtask

   // Load a word while idle, then switch the expected IR fields to it.
   task automatic ld(input string tag, input logic [15:0] word, input logic [1:0] sh,
                     input logic [1:0] al, input logic [15:0] x8, input logic [15:0] x5);
      $display("issue %s instr=%h", tag, word);
      in   = word;
      load = 1'b1;
      ex({tag, "_load"}, 1'b1, 3'd0, 3'd0, S_NONE, 2'b00);
      step();
      load = 1'b0;
      setf(sh, al, x8, x5);
   endtask

   task automatic go(input string tag);
      s = 1'b1;
      ex({tag, "_start"}, 1'b1, 3'd0, 3'd0, S_NONE, 2'b00);
      step();
      s = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      s       = 1'b0;
      load    = 1'b0;
      in      = 16'h0000;
      step();
      step();
      ex("reset", 1'b1, 3'd0, 3'd0, S_NONE, 2'b00);
      step();
      reset_n = 1'b1;
      ex("idle", 1'b1, 3'd0, 3'd0, S_NONE, 2'b00);
      step();

      // MOVI R2, #-5
      ld("movi", 16'hD2FB, 2'b11, 2'b10, 16'hFFFB, 16'hFFFB);
      go("movi");
      ex("movi_dec",   1'b0, 3'd0, 3'd0, S_NONE, 2'b00); step();
      ex("movi_wrimm", 1'b0, 3'd0, 3'd2, S_WR,   2'b10); step();
      ex("movi_done",  1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();

      // ADD R5, R0, R1
      ld("add", 16'hA0A1, 2'b00, 2'b00, 16'hFFA1, 16'h0001);
      go("add");
      ex("add_dec",   1'b0, 3'd0, 3'd0, S_NONE, 2'b00); step();
      ex("add_geta",  1'b0, 3'd0, 3'd0, S_LA,   2'b00); step();
      ex("add_getb",  1'b0, 3'd1, 3'd0, S_LB,   2'b00); step();
      ex("add_alu",   1'b0, 3'd0, 3'd0, S_LC,   2'b00); step();
      ex("add_wrreg", 1'b0, 3'd0, 3'd5, S_WR,   2'b00); step();
      ex("add_done",  1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();

      // CMP R1, R3, LSL#1
      ld("cmp", 16'hA90B, 2'b01, 2'b01, 16'h000B, 16'h000B);
      go("cmp");
      ex("cmp_dec",  1'b0, 3'd0, 3'd0, S_NONE, 2'b00); step();
      ex("cmp_geta", 1'b0, 3'd1, 3'd0, S_LA,   2'b00); step();
      ex("cmp_getb", 1'b0, 3'd3, 3'd0, S_LB,   2'b00); step();
      ex("cmp_alu",  1'b0, 3'd0, 3'd0, S_LS,   2'b00); step();
      ex("cmp_done", 1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();

      // MOVR R7, R0 with shift 10; a mid-instruction load must be ignored
      ld("movr", 16'hC0F0, 2'b10, 2'b00, 16'hFFF0, 16'hFFF0);
      go("movr");
      in   = 16'hFFFF;
      load = 1'b1;
      ex("movr_dec",   1'b0, 3'd0, 3'd0, S_NONE,      2'b00); step();
      ex("movr_getb",  1'b0, 3'd0, 3'd0, S_LB,        2'b00); step();
      load = 1'b0;
      ex("movr_alu",   1'b0, 3'd0, 3'd0, S_LC | S_AS, 2'b00); step();
      ex("movr_wrreg", 1'b0, 3'd0, 3'd7, S_WR,        2'b00); step();
      ex("movr_done",  1'b1, 3'd0, 3'd0, S_NONE,      2'b00); step();

      // illegal word, loaded on the same edge as the start
      $display("issue illegal instr=e000");
      in   = 16'hE000;
      load = 1'b1;
      s    = 1'b1;
      ex("ill_start", 1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();
      load = 1'b0;
      s    = 1'b0;
      setf(2'b00, 2'b00, 16'h0000, 16'h0000);
      ex("ill_dec",  1'b0, 3'd0, 3'd0, S_NONE, 2'b00); step();
      ex("ill_done", 1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();
      ex("ill_idle", 1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();

      // MVN R3, R6 LSL#1 loaded with s on the same edge, s held for two runs
      $display("issue mvn x2 instr=b86e");
      in   = 16'hB86E;
      load = 1'b1;
      s    = 1'b1;
      ex("mvn_start", 1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();
      load = 1'b0;
      setf(2'b01, 2'b11, 16'h006E, 16'h000E);
      ex("mvn1_dec",   1'b0, 3'd0, 3'd0, S_NONE, 2'b00); step();
      ex("mvn1_getb",  1'b0, 3'd6, 3'd0, S_LB,   2'b00); step();
      ex("mvn1_alu",   1'b0, 3'd0, 3'd0, S_LC,   2'b00); step();
      ex("mvn1_wrreg", 1'b0, 3'd0, 3'd3, S_WR,   2'b00); step();
      ex("mvn_between", 1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();
      s = 1'b0;
      ex("mvn2_dec",   1'b0, 3'd0, 3'd0, S_NONE, 2'b00); step();
      ex("mvn2_getb",  1'b0, 3'd6, 3'd0, S_LB,   2'b00); step();
      ex("mvn2_alu",   1'b0, 3'd0, 3'd0, S_LC,   2'b00); step();
      ex("mvn2_wrreg", 1'b0, 3'd0, 3'd3, S_WR,   2'b00); step();
      ex("mvn_done",   1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();

      // reset asserted while an ADD sits in GET_B
      ld("rstadd", 16'hA0A1, 2'b00, 2'b00, 16'hFFA1, 16'h0001);
      go("rstadd");
      ex("rstadd_dec",  1'b0, 3'd0, 3'd0, S_NONE, 2'b00); step();
      ex("rstadd_geta", 1'b0, 3'd0, 3'd0, S_LA,   2'b00); step();
      reset_n = 1'b0;
      ex("rstadd_getb_masked", 1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();
      reset_n = 1'b1;
      setf(2'b00, 2'b00, 16'h0000, 16'h0000);
      ex("rstadd_wait", 1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();
      ex("rstadd_idle", 1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();
      ex("rstadd_idle2", 1'b1, 3'd0, 3'd0, S_NONE, 2'b00); step();

      step();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
